// File: rtl/systolic_pkg.sv
// systolic_pkg: shared state encoding and default dimensions for the systolic sequencer
package systolic_pkg;
  localparam int N_DEF = 4;
  localparam int DATA_WIDTH_DEF = 8;
  localparam int ACC_WIDTH_DEF = 32;
  localparam int K_MAX_DEF = 256;
  typedef enum logic [2:0] {IDLE, CLEAR, FEED, OUT, DONE} state_t;
endpackage

// File: rtl/systolic_ctrl_skew_line.sv
// skew_line: DEPTH-stage delay line with synchronous clear; DEPTH=0 is a wire
module skew_line #(
  parameter int W = 8,
  parameter int DEPTH = 1
) (
  input  logic         clk,
  input  logic         clr,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  if (DEPTH == 0) begin : g_pass
    logic unused_ok;
    assign unused_ok = &{1'b0, clk, clr};
    assign q = d;
  end else begin : g_reg
    logic [W-1:0] sr [DEPTH];
    always_ff @(posedge clk) begin
      if (clr) begin
        for (int s = 0; s < DEPTH; s++) sr[s] <= '0;
      end else begin
        sr[0] <= d;
        for (int s = 1; s < DEPTH; s++) sr[s] <= sr[s-1];
      end
    end
    assign q = sr[DEPTH-1];
  end
endmodule

// File: rtl/systolic_ctrl.sv
// systolic_ctrl: clears, feeds with diagonal skew, then drains an NxN output-stationary array
module systolic_ctrl import systolic_pkg::*; #(
  parameter int N = N_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ACC_WIDTH = ACC_WIDTH_DEF,
  parameter int K_MAX = K_MAX_DEF,
  parameter int K_W = $clog2(K_MAX + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [K_W-1:0]            k_len,
  output logic                      busy,
  output logic                      done,
  output logic                      op_rd_en,
  output logic [K_W-1:0]            op_rd_addr,
  input  logic [N*DATA_WIDTH-1:0]   op_a_data,
  input  logic [N*DATA_WIDTH-1:0]   op_b_data,
  output logic                      arr_clr,
  output logic [N*DATA_WIDTH-1:0]   arr_a_in,
  output logic [N*DATA_WIDTH-1:0]   arr_b_in,
  input  logic [N*N*ACC_WIDTH-1:0]  arr_psum,
  output logic                      res_valid,
  input  logic                      res_ready,
  output logic [ACC_WIDTH-1:0]      res_data,
  output logic [$clog2(N)-1:0]      res_row,
  output logic [$clog2(N)-1:0]      res_col
);
  localparam int IW = $clog2(N);
  localparam int T_W = $clog2(K_MAX + 2*N);
  state_t state;
  logic [K_W-1:0] k;
  logic [T_W-1:0] t, tn, t_end;
  logic rd_en_q, skew_clr, last;
  assign tn = t + 1'b1;
  assign t_end = T_W'(k) + T_W'(2*N - 2);
  assign last = res_row == IW'(N-1) && res_col == IW'(N-1);
  assign skew_clr = rst || state != FEED;
  always_comb res_data = res_valid ? arr_psum[(int'(res_row)*N + int'(res_col))*ACC_WIDTH +: ACC_WIDTH] : '0;
  // read data is only meaningful the cycle after a strobe; otherwise lanes inject zeros
  for (genvar g = 0; g < N; g++) begin : g_lane
    skew_line #(.W(DATA_WIDTH), .DEPTH(g)) a_line (
      .clk(clk), .clr(skew_clr),
      .d(rd_en_q ? op_a_data[g*DATA_WIDTH +: DATA_WIDTH] : '0),
      .q(arr_a_in[g*DATA_WIDTH +: DATA_WIDTH])
    );
    skew_line #(.W(DATA_WIDTH), .DEPTH(g)) b_line (
      .clk(clk), .clr(skew_clr),
      .d(rd_en_q ? op_b_data[g*DATA_WIDTH +: DATA_WIDTH] : '0),
      .q(arr_b_in[g*DATA_WIDTH +: DATA_WIDTH])
    );
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      k <= '0;
      t <= '0;
      rd_en_q <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      op_rd_en <= 1'b0;
      op_rd_addr <= '0;
      arr_clr <= 1'b0;
      res_valid <= 1'b0;
      res_row <= '0;
      res_col <= '0;
    end else begin
      rd_en_q <= op_rd_en;
      done <= 1'b0;
      arr_clr <= 1'b0;
      case (state)
        IDLE: if (start) begin
          k <= k_len;
          busy <= 1'b1;
          arr_clr <= 1'b1;
          state <= CLEAR;
        end
        CLEAR: begin
          t <= '0;
          res_row <= '0;
          res_col <= '0;
          op_rd_addr <= '0;
          op_rd_en <= k != '0;
          res_valid <= k == '0;
          state <= k == '0 ? OUT : FEED;
        end
        FEED: begin
          t <= tn;
          op_rd_en <= tn < T_W'(k);
          op_rd_addr <= tn < T_W'(k) ? K_W'(tn) : '0;
          if (t == t_end) begin
            res_valid <= 1'b1;
            state <= OUT;
          end
        end
        OUT: if (res_ready) begin
          if (last) begin
            res_valid <= 1'b0;
            done <= 1'b1;
            state <= DONE;
          end else begin
            res_col <= res_col == IW'(N-1) ? '0 : res_col + 1'b1;
            res_row <= res_col == IW'(N-1) ? res_row + 1'b1 : res_row;
          end
        end
        DONE: begin
          busy <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
